pcie_egress_split: RTL and testbench

//  Parametrised TLP egress builder for the Artemis PCIe platform. Takes one request (command, flags, address,

---
 rtl/pcie_egress_split_pkg.sv | 27 ++
 rtl/pcie_egress_split_len_calc.sv | 25 ++
 rtl/pcie_egress_split.sv | 206 ++++++++++++++++++++
 tb/tb_pcie_egress_split.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_egress_split_pkg.sv
// Shared constants, state encoding and header helpers for the PCIe egress TLP builder.
package pcie_egress_split_pkg;

    localparam logic [7:0] PCIE_MWR_32B = 8'h40;
    localparam logic [7:0] PCIE_MWR_64B = 8'h60;
    localparam logic [7:0] PCIE_MRD_32B = 8'h00;
    localparam logic [7:0] PCIE_MRD_64B = 8'h20;

    localparam int CMD_4DW_BIT  = 5;
    localparam int CMD_DATA_BIT = 6;
    localparam int PCIE_4K_DW   = 1024;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_WAIT_FOR_FIFO = 3'd1,
        ST_LOAD          = 3'd2,
        ST_SEND_HDR      = 3'd3,
        ST_SEND_DATA     = 3'd4,
        ST_FINISHED      = 3'd5
    } state_e;

    // Byte enables in dword1: a single-dword TLP uses first-BE only (last-BE must be zero).
    function automatic logic [7:0] hdr_byte_enables(input logic [10:0] len);
        return (len == 11'd1) ? 8'h0F : 8'hFF;
    endfunction

endpackage

// File: rtl/pcie_egress_split_len_calc.sv
// Payload length of the next MWr TLP: bounded by remaining dwords, max payload and the 4 KB page end.
module pcie_egress_split_len_calc
    import pcie_egress_split_pkg::*;
#(
    parameter int MAX_PAYLOAD_DW = 32,
    parameter int SIZE_WIDTH     = 24
) (
    input  logic [SIZE_WIDTH-1:0] remaining_i,
    input  logic [9:0]            addr_dw_i,
    output logic [10:0]           len_o
);

    localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD_DW);

    logic [10:0] page_left;
    logic [10:0] cap;

    always_comb begin
        // 11 bits so that a page-aligned address yields a full 1024 dwords.
        page_left = 11'(PCIE_4K_DW) - {1'b0, addr_dw_i};
        cap       = (page_left < MAX_LEN) ? page_left : MAX_LEN;
        len_o     = (remaining_i < SIZE_WIDTH'(cap)) ? remaining_i[10:0] : cap;
    end

endmodule

// File: rtl/pcie_egress_split.sv
// Builds MWr/MRd TLPs onto a 32-bit AXI-Stream, splitting a FIFO block at max payload and 4 KB pages.
module pcie_egress_split
    import pcie_egress_split_pkg::*;
#(
    parameter int MAX_PAYLOAD_DW = 32,
    parameter int SIZE_WIDTH     = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    output logic                  o_finished,
    input  logic [7:0]            i_command,
    input  logic [13:0]           i_flags,
    input  logic [63:0]           i_address,
    input  logic [15:0]           i_requester_id,
    input  logic [7:0]            i_tag,
    input  logic                  i_axi_egress_ready,
    output logic [31:0]           o_axi_egress_data,
    output logic [3:0]            o_axi_egress_keep,
    output logic                  o_axi_egress_last,
    output logic                  o_axi_egress_valid,
    input  logic                  i_fifo_rdy,
    output logic                  o_fifo_act,
    input  logic [SIZE_WIDTH-1:0] i_fifo_size,
    input  logic [31:0]           i_fifo_data,
    output logic                  o_fifo_stb,
    output logic [15:0]           o_tlp_count,
    output state_e                o_dbg_state
);

    // Stream contract: a beat fires on valid & ready; once valid rises, data and last
    // hold until that beat fires, and valid never falls without a fire (except reset).

    state_e                state_q, state_d;
    logic [61:0]           addr_q, addr_d;      // dword address, byte address bits [63:2]
    logic [7:0]            cmd_q, cmd_d;
    logic [13:0]           flags_q, flags_d;
    logic [15:0]           req_id_q, req_id_d;
    logic [7:0]            tag_q, tag_d;
    logic [SIZE_WIDTH-1:0] remaining_q, remaining_d;
    logic [10:0]           len_q, len_d;
    logic [10:0]           beat_cnt_q, beat_cnt_d;
    logic [1:0]            hdr_idx_q, hdr_idx_d;
    logic                  fifo_act_q, fifo_act_d;
    logic [15:0]           tlp_count_q, tlp_count_d;

    logic [10:0] calc_len;
    logic        is_4dw;
    logic        is_mrd;
    logic [1:0]  hdr_last_idx;
    logic [31:0] hdr_word;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^i_address[1:0];

    pcie_egress_split_len_calc #(
        .MAX_PAYLOAD_DW (MAX_PAYLOAD_DW),
        .SIZE_WIDTH     (SIZE_WIDTH)
    ) u_len_calc (
        .remaining_i (remaining_q),
        .addr_dw_i   (addr_q[9:0]),
        .len_o       (calc_len)
    );

    assign is_4dw       = cmd_q[CMD_4DW_BIT];
    assign is_mrd       = ~cmd_q[CMD_DATA_BIT];
    assign hdr_last_idx = is_4dw ? 2'd3 : 2'd2;

    always_comb begin
        hdr_word = 32'h0;
        case (hdr_idx_q)
            2'd0: hdr_word = {cmd_q, flags_q, len_q[9:0]};
            2'd1: hdr_word = {req_id_q, (is_mrd ? tag_q : 8'h00), hdr_byte_enables(len_q)};
            2'd2: hdr_word = is_4dw ? addr_q[61:30] : {addr_q[29:0], 2'b00};
            default: hdr_word = {addr_q[29:0], 2'b00};
        endcase
    end

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        cmd_d              = cmd_q;
        flags_d            = flags_q;
        req_id_d           = req_id_q;
        tag_d              = tag_q;
        remaining_d        = remaining_q;
        len_d              = len_q;
        beat_cnt_d         = beat_cnt_q;
        hdr_idx_d          = hdr_idx_q;
        fifo_act_d         = fifo_act_q;
        tlp_count_d        = tlp_count_q;
        o_axi_egress_valid = 1'b0;
        o_axi_egress_last  = 1'b0;
        o_axi_egress_data  = 32'h0;
        o_fifo_stb         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    addr_d      = i_address[63:2];
                    cmd_d       = i_command;
                    flags_d     = i_flags;
                    req_id_d    = i_requester_id;
                    tag_d       = i_tag;
                    tlp_count_d = 16'h0;
                    if (!i_command[CMD_DATA_BIT]) begin
                        state_d = ST_LOAD;
                    end else if (i_fifo_size == '0) begin
                        state_d = ST_FINISHED;
                    end else begin
                        state_d = ST_WAIT_FOR_FIFO;
                    end
                end
            end
            ST_WAIT_FOR_FIFO: begin
                if (i_fifo_rdy && !fifo_act_q) begin
                    fifo_act_d  = 1'b1;
                    remaining_d = i_fifo_size;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Reads carry their length directly; 0 in the low ten bits means 1024.
                if (is_mrd) begin
                    len_d = {(i_fifo_size[9:0] == 10'd0), i_fifo_size[9:0]};
                end else begin
                    len_d = calc_len;
                end
                beat_cnt_d = len_d;
                hdr_idx_d  = 2'd0;
                state_d    = ST_SEND_HDR;
            end
            ST_SEND_HDR: begin
                o_axi_egress_valid = 1'b1;
                o_axi_egress_data  = hdr_word;
                o_axi_egress_last  = is_mrd && (hdr_idx_q == hdr_last_idx);
                if (i_axi_egress_ready) begin
                    if (hdr_idx_q == hdr_last_idx) begin
                        state_d = is_mrd ? ST_FINISHED : ST_SEND_DATA;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end
            ST_SEND_DATA: begin
                o_axi_egress_valid = 1'b1;
                o_axi_egress_data  = i_fifo_data;
                o_axi_egress_last  = (beat_cnt_q == 11'd1);
                if (i_axi_egress_ready) begin
                    o_fifo_stb = 1'b1;
                    beat_cnt_d = beat_cnt_q - 11'd1;
                    if (beat_cnt_q == 11'd1) begin
                        remaining_d = remaining_q - SIZE_WIDTH'(len_q);
                        addr_d      = addr_q + 62'(len_q);
                        tlp_count_d = tlp_count_q + 16'd1;
                        state_d     = (remaining_q == SIZE_WIDTH'(len_q)) ? ST_FINISHED : ST_LOAD;
                    end
                end
            end
            ST_FINISHED: begin
                fifo_act_d = 1'b0;
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cmd_q       <= 8'h0;
            flags_q     <= 14'h0;
            req_id_q    <= 16'h0;
            tag_q       <= 8'h0;
            remaining_q <= '0;
            len_q       <= 11'h0;
            beat_cnt_q  <= 11'h0;
            hdr_idx_q   <= 2'd0;
            fifo_act_q  <= 1'b0;
            tlp_count_q <= 16'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            flags_q     <= flags_d;
            req_id_q    <= req_id_d;
            tag_q       <= tag_d;
            remaining_q <= remaining_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            hdr_idx_q   <= hdr_idx_d;
            fifo_act_q  <= fifo_act_d;
            tlp_count_q <= tlp_count_d;
        end
    end

    assign o_finished        = (state_q == ST_FINISHED);
    assign o_fifo_act        = fifo_act_q;
    assign o_tlp_count       = tlp_count_q;
    assign o_axi_egress_keep = 4'hF;
    assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_pcie_egress_split.sv
// Directed bench for pcie_egress_split: MWr splitting, page boundaries, backpressure, MRd and reset.
module tb_pcie_egress_split;
    import pcie_egress_split_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_enable;
    logic        o_finished;
    logic [7:0]  i_command;
    logic [13:0] i_flags;
    logic [63:0] i_address;
    logic [15:0] i_requester_id;
    logic [7:0]  i_tag;
    logic        i_axi_egress_ready;
    logic [31:0] o_axi_egress_data;
    logic [3:0]  o_axi_egress_keep;
    logic        o_axi_egress_last;
    logic        o_axi_egress_valid;
    logic        i_fifo_rdy;
    logic        o_fifo_act;
    logic [23:0] i_fifo_size;
    logic [31:0] i_fifo_data;
    logic        o_fifo_stb;
    logic [15:0] o_tlp_count;
    state_e      o_dbg_state;

    int checks = 0;
    int errors = 0;

    pcie_egress_split #(.MAX_PAYLOAD_DW(32), .SIZE_WIDTH(24)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_enable           (i_enable),
        .o_finished         (o_finished),
        .i_command          (i_command),
        .i_flags            (i_flags),
        .i_address          (i_address),
        .i_requester_id     (i_requester_id),
        .i_tag              (i_tag),
        .i_axi_egress_ready (i_axi_egress_ready),
        .o_axi_egress_data  (o_axi_egress_data),
        .o_axi_egress_keep  (o_axi_egress_keep),
        .o_axi_egress_last  (o_axi_egress_last),
        .o_axi_egress_valid (o_axi_egress_valid),
        .i_fifo_rdy         (i_fifo_rdy),
        .o_fifo_act         (o_fifo_act),
        .i_fifo_size        (i_fifo_size),
        .i_fifo_data        (i_fifo_data),
        .o_fifo_stb         (o_fifo_stb),
        .o_tlp_count        (o_tlp_count),
        .o_dbg_state        (o_dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // FIFO model: head word is a known pattern indexed by pop count.
    logic [31:0] fifo_ptr = 32'h0;
    always @(posedge clk) if (o_fifo_stb) fifo_ptr <= fifo_ptr + 32'd1;
    assign i_fifo_data = 32'hD000_0000 + fifo_ptr;

    // Stream monitor: capture fired beats and count protocol violations.
    logic [31:0] beat_data[$];
    logic        beat_last[$];
    int          stb_total   = 0;
    int          act_cycles  = 0;
    int          drop_viol   = 0;
    int          stall_viol  = 0;
    bit          in_tlp      = 0;
    bit          prev_stall  = 0;
    logic [31:0] prev_data   = 32'h0;
    logic        prev_last   = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            in_tlp     = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall && (!o_axi_egress_valid || o_axi_egress_data !== prev_data ||
                               o_axi_egress_last !== prev_last))
                stall_viol++;
            if (o_axi_egress_valid && i_axi_egress_ready) begin
                beat_data.push_back(o_axi_egress_data);
                beat_last.push_back(o_axi_egress_last);
                in_tlp = !o_axi_egress_last;
            end else if (in_tlp && !o_axi_egress_valid) begin
                drop_viol++;
            end
            prev_stall = o_axi_egress_valid && !i_axi_egress_ready;
            prev_data  = o_axi_egress_data;
            prev_last  = o_axi_egress_last;
            if (o_fifo_stb) stb_total++;
            if (o_fifo_act) act_cycles++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_req(input logic [7:0] cmd, input logic [63:0] addr,
                           input logic [23:0] size, input logic [7:0] tag, input bit toggle,
                           output bit done, output logic [15:0] tlp_cnt, output int first_valid);
        i_command   = cmd;
        i_address   = addr;
        i_fifo_size = size;
        i_tag       = tag;
        i_enable    = 1'b1;
        done        = 0;
        first_valid = -1;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk);
            #1;
            if (first_valid < 0 && o_axi_egress_valid) first_valid = i;
            if (toggle) i_axi_egress_ready = ~i_axi_egress_ready;
            if (o_finished) done = 1;
        end
        tlp_cnt            = o_tlp_count;
        i_enable           = 1'b0;
        i_axi_egress_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic int count_lasts(input int from);
        int n = 0;
        for (int i = from; i < beat_last.size(); i++) if (beat_last[i]) n++;
        return n;
    endfunction

    bit          done;
    logic [15:0] tlp_cnt;
    int          fv;
    int          b0;
    int          s0;
    int          a0;
    int          d0;
    int          t0;
    logic [31:0] base;
    int          mism;

    initial begin
        i_enable           = 1'b0;
        i_command          = PCIE_MWR_32B;
        i_flags            = 14'h0;
        i_address          = 64'h0;
        i_requester_id     = 16'h0100;
        i_tag              = 8'h00;
        i_axi_egress_ready = 1'b1;
        i_fifo_rdy         = 1'b1;
        i_fifo_size        = 24'd0;
        rst                = 1'b0;
        do_reset();

        check("rst_valid", o_axi_egress_valid, 1'b0);
        check("rst_last", o_axi_egress_last, 1'b0);
        check("rst_finished", o_finished, 1'b0);
        check("rst_fifo_act", o_fifo_act, 1'b0);
        check("rst_fifo_stb", o_fifo_stb, 1'b0);
        check("rst_tlp_count", o_tlp_count, 16'h0);
        check("rst_state", o_dbg_state, ST_IDLE);
        check("rst_keep", o_axi_egress_keep, 4'hF);

        // 1: single-dword MWr32 with flags
        b0 = beat_data.size(); s0 = stb_total; base = fifo_ptr;
        i_flags = 14'h2A5;
        run_req(PCIE_MWR_32B, 64'h1000, 24'd1, 8'h00, 0, done, tlp_cnt, fv);
        i_flags = 14'h0;
        check("t1_done", done, 1'b1);
        check("t1_latency", fv, 2);
        check("t1_beats", beat_data.size() - b0, 4);
        check("t1_hdr0", beat_data[b0], 32'h400A_9401);
        check("t1_hdr1", beat_data[b0+1], 32'h0100_000F);
        check("t1_hdr2", beat_data[b0+2], 32'h0000_1000);
        check("t1_data", beat_data[b0+3], 32'hD000_0000 + base);
        check("t1_lasts", {beat_last[b0+3], beat_last[b0+2], beat_last[b0+1], beat_last[b0]}, 4'b1000);
        check("t1_stb", stb_total - s0, 1);
        check("t1_tlp_count", tlp_cnt, 16'd1);
        check("t1_finished_drop", o_finished, 1'b0);
        check("t1_fifo_act_drop", o_fifo_act, 1'b0);

        // 2: 80 dwords split 32/32/16
        b0 = beat_data.size(); s0 = stb_total; base = fifo_ptr;
        run_req(PCIE_MWR_32B, 64'h0, 24'd80, 8'h00, 0, done, tlp_cnt, fv);
        check("t2_done", done, 1'b1);
        check("t2_beats", beat_data.size() - b0, 89);
        check("t2_tlp1_hdr0", beat_data[b0], 32'h4000_0020);
        check("t2_tlp1_hdr1", beat_data[b0+1], 32'h0100_00FF);
        check("t2_tlp1_addr", beat_data[b0+2], 32'h0000_0000);
        check("t2_tlp2_hdr0", beat_data[b0+35], 32'h4000_0020);
        check("t2_tlp2_addr", beat_data[b0+37], 32'h0000_0080);
        check("t2_tlp3_hdr0", beat_data[b0+70], 32'h4000_0010);
        check("t2_tlp3_addr", beat_data[b0+72], 32'h0000_0100);
        check("t2_data_first", beat_data[b0+3], 32'hD000_0000 + base);
        check("t2_data_tlp2", beat_data[b0+38], 32'hD000_0000 + base + 32);
        check("t2_data_last", beat_data[b0+88], 32'hD000_0000 + base + 79);
        check("t2_last_pos", {beat_last[b0+34], beat_last[b0+69], beat_last[b0+88]}, 3'b111);
        check("t2_last_count", count_lasts(b0), 3);
        check("t2_stb", stb_total - s0, 80);
        check("t2_tlp_count", tlp_cnt, 16'd3);

        // 3: 4 KB page crossing at 0xFF8
        b0 = beat_data.size();
        run_req(PCIE_MWR_32B, 64'hFF8, 24'd8, 8'h00, 0, done, tlp_cnt, fv);
        check("t3_done", done, 1'b1);
        check("t3_beats", beat_data.size() - b0, 14);
        check("t3_tlp1_hdr0", beat_data[b0], 32'h4000_0002);
        check("t3_tlp1_addr", beat_data[b0+2], 32'h0000_0FF8);
        check("t3_tlp2_hdr0", beat_data[b0+5], 32'h4000_0006);
        check("t3_tlp2_addr", beat_data[b0+7], 32'h0000_1000);
        check("t3_last_pos", {beat_last[b0+4], beat_last[b0+13]}, 2'b11);
        check("t3_tlp_count", tlp_cnt, 16'd2);

        // 4: 40 dwords with ready toggling every cycle
        b0 = beat_data.size(); s0 = stb_total; base = fifo_ptr; d0 = drop_viol; t0 = stall_viol;
        run_req(PCIE_MWR_32B, 64'h2000, 24'd40, 8'h00, 1, done, tlp_cnt, fv);
        check("t4_done", done, 1'b1);
        check("t4_beats", beat_data.size() - b0, 46);
        mism = 0;
        for (int i = 0; i < 32; i++) if (beat_data[b0+3+i] !== 32'hD000_0000 + base + i) mism++;
        for (int i = 0; i < 8; i++) if (beat_data[b0+38+i] !== 32'hD000_0000 + base + 32 + i) mism++;
        check("t4_data_order", mism, 0);
        check("t4_tlp2_hdr0", beat_data[b0+35], 32'h4000_0008);
        check("t4_tlp2_addr", beat_data[b0+37], 32'h0000_2080);
        check("t4_valid_drop", drop_viol - d0, 0);
        check("t4_stall_hold", stall_viol - t0, 0);
        check("t4_stb", stb_total - s0, 40);
        check("t4_tlp_count", tlp_cnt, 16'd2);

        // 5: MRd64 above 4 GB
        b0 = beat_data.size(); s0 = stb_total; a0 = act_cycles;
        run_req(PCIE_MRD_64B, 64'h1_0000_0040, 24'd16, 8'h5A, 0, done, tlp_cnt, fv);
        check("t5_done", done, 1'b1);
        check("t5_latency", fv, 1);
        check("t5_beats", beat_data.size() - b0, 4);
        check("t5_hdr0", beat_data[b0], 32'h2000_0010);
        check("t5_hdr1", beat_data[b0+1], 32'h0100_5AFF);
        check("t5_hdr2", beat_data[b0+2], 32'h0000_0001);
        check("t5_hdr3", beat_data[b0+3], 32'h0000_0040);
        check("t5_lasts", {beat_last[b0+3], beat_last[b0+2], beat_last[b0+1], beat_last[b0]}, 4'b1000);
        check("t5_fifo_act", act_cycles - a0, 0);
        check("t5_stb", stb_total - s0, 0);

        // 6: reset during SEND_DATA, then a normal request
        b0 = beat_data.size();
        i_command = PCIE_MWR_32B; i_address = 64'h3000; i_fifo_size = 24'd40; i_enable = 1'b1;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            if (o_dbg_state == ST_SEND_DATA && beat_data.size() >= b0 + 6) done = 1;
        end
        check("t6_reached_data", done, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_valid", o_axi_egress_valid, 1'b0);
        check("t6_fifo_act", o_fifo_act, 1'b0);
        check("t6_state", o_dbg_state, ST_IDLE);
        i_enable = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        b0 = beat_data.size(); base = fifo_ptr;
        run_req(PCIE_MWR_32B, 64'h4000, 24'd2, 8'h00, 0, done, tlp_cnt, fv);
        check("t6_done", done, 1'b1);
        check("t6_beats", beat_data.size() - b0, 5);
        check("t6_hdr0", beat_data[b0], 32'h4000_0002);
        check("t6_addr", beat_data[b0+2], 32'h0000_4000);
        check("t6_data0", beat_data[b0+3], 32'hD000_0000 + base);
        check("t6_data1", beat_data[b0+4], 32'hD000_0000 + base + 1);
        check("t6_tlp_count", tlp_cnt, 16'd1);

        // 7: zero-size MWr finishes with no TLP
        b0 = beat_data.size(); s0 = stb_total; a0 = act_cycles;
        run_req(PCIE_MWR_32B, 64'h5000, 24'd0, 8'h00, 0, done, tlp_cnt, fv);
        check("t7_done", done, 1'b1);
        check("t7_beats", beat_data.size() - b0, 0);
        check("t7_tlp_count", tlp_cnt, 16'd0);
        check("t7_fifo_act", act_cycles - a0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
